// File: rtl/hash_resp_buffer.sv
// hash_resp_buffer
//
// Buffers 32-bit response words from a hash table on their way to a host.
// It is a DEPTH-entry FIFO. Each stored word has its reserved bits [27:26]
// cleared. For every accepted word, one saturating counter per error flag is
// incremented. On the output side the block marks every BATCH-th beat with
// m_last_o.
//
// Ports
//   clk           sole clock, rising edge
//   reset         asynchronous, active-high reset
//   s_data_i      response word: [31] key_already_present, [30] no_element_found,
//                 [29] no_write_space, [28] no_deletion_target, [27:26] reserved,
//                 [DATA_WIDTH-1:0] read data
//   s_valid_i     s_data_i valid
//   s_ready_o     buffer can accept a word (level < DEPTH)
//   m_data_o      oldest buffered word (zero while empty)
//   m_valid_o     m_data_o valid (level > 0)
//   m_ready_i     host accepts the word
//   m_last_o      final beat of a BATCH group
//   clear_i       synchronous zeroing of the error counters
//   err_counts_o  {key_already_present, no_element_found, no_write_space,
//                  no_deletion_target} counters, CNT_WIDTH bits each
//   level_o       current FIFO occupancy
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. Ready never depends on valid, and valid never depends on ready. Once
// m_valid_o is raised, it and m_data_o hold until the host accepts the word.
module hash_resp_buffer #(
    parameter int KEY_WIDTH  = 4,
    parameter int DATA_WIDTH = 26,
    parameter int DEPTH      = 8,
    parameter int BATCH      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [31:0]               s_data_i,
    input  logic                      s_valid_i,
    output logic                      s_ready_o,
    output logic [31:0]               m_data_o,
    output logic                      m_valid_o,
    input  logic                      m_ready_i,
    output logic                      m_last_o,
    input  logic                      clear_i,
    output logic [4*CNT_WIDTH-1:0]    err_counts_o,
    output logic [$clog2(DEPTH):0]    level_o
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int BEAT_W = (BATCH > 1) ? $clog2(BATCH) : 1;

    localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(DEPTH);
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BATCH - 1);
    // Flags and read data pass through unchanged. The reserved field between
    // them is dropped.
    localparam logic [31:0] KEEP_MASK =
        32'hF000_0000 | 32'((64'd1 << DATA_WIDTH) - 64'd1);

    if ((KEY_WIDTH + DATA_WIDTH + 2 != 32) || (DEPTH < 2) ||
        ((1 << PTR_W) != DEPTH) || (BATCH < 1)) begin : g_bad_params
        $error("hash_resp_buffer: illegal parameter combination");
    end

    logic [31:0]          mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [CNT_WIDTH-1:0] cnt_q [4];
    logic [CNT_WIDTH-1:0] cnt_d [4];
    logic                 push, pop;

    // Both handshake outputs come from the level register only.
    assign s_ready_o = (level_q < FULL_LVL);
    assign m_valid_o = (level_q != '0);
    assign push      = s_valid_i && s_ready_o;
    assign pop       = m_valid_o && m_ready_i;

    // Gating on m_valid_o makes m_data_o read zero as soon as reset clears the
    // level. The memory itself therefore needs no reset.
    assign m_data_o     = m_valid_o ? mem_q[rd_ptr_q] : 32'h0;
    assign m_last_o     = m_valid_o && (beat_q == BEAT_MAX);
    assign level_o      = level_q;
    assign err_counts_o = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        beat_d   = beat_q;

        // Pointers wrap naturally because DEPTH is a power of two.
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            beat_d   = (beat_q == BEAT_MAX) ? '0 : beat_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clear_i) begin
                cnt_d[i] = '0;
            end else if (push && s_data_i[28+i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            beat_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            beat_q   <= beat_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data_i & KEEP_MASK;
        end
    end

endmodule

// File: tb/tb_hash_resp_buffer.sv
// Testbench for hash_resp_buffer. It checks a default-parameter instance
// against a queue-based reference model. It also exercises a small instance
// (DEPTH=4, BATCH=1, CNT_WIDTH=2) for the saturation and single-beat-batch cases.
module tb_hash_resp_buffer;
  localparam int DEPTH     = 8;
  localparam int BATCH     = 4;
  localparam int CNT_WIDTH = 16;
  localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // main instance
  logic [31:0]            s_data_i;
  logic                   s_valid_i, s_ready_o;
  logic [31:0]            m_data_o;
  logic                   m_valid_o, m_ready_i, m_last_o, clear_i;
  logic [4*CNT_WIDTH-1:0] err_counts_o;
  logic [3:0]             level_o;

  hash_resp_buffer #(
    .KEY_WIDTH(4), .DATA_WIDTH(26), .DEPTH(DEPTH), .BATCH(BATCH), .CNT_WIDTH(CNT_WIDTH)
  ) u_dut (
    .clk(clk), .reset(reset),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_last_o(m_last_o), .clear_i(clear_i),
    .err_counts_o(err_counts_o), .level_o(level_o)
  );

  // small instance
  logic [31:0] sm_s_data;
  logic        sm_s_valid, sm_s_ready;
  logic [31:0] sm_m_data;
  logic        sm_m_valid, sm_m_ready, sm_m_last, sm_clear;
  logic [7:0]  sm_err;
  logic [2:0]  sm_level;

  hash_resp_buffer #(
    .KEY_WIDTH(4), .DATA_WIDTH(26), .DEPTH(4), .BATCH(1), .CNT_WIDTH(2)
  ) u_small (
    .clk(clk), .reset(reset),
    .s_data_i(sm_s_data), .s_valid_i(sm_s_valid), .s_ready_o(sm_s_ready),
    .m_data_o(sm_m_data), .m_valid_o(sm_m_valid), .m_ready_i(sm_m_ready),
    .m_last_o(sm_m_last), .clear_i(sm_clear),
    .err_counts_o(sm_err), .level_o(sm_level)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [31:0] exp_q[$];
  int cnt_m[4];
  int pops_m;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < 4; i++) cnt_m[i] = 0;
    pops_m = 0;
  endtask

  task automatic check_model();
    int sz;
    logic [63:0] ec;
    sz = exp_q.size();
    ec = {16'(cnt_m[3]), 16'(cnt_m[2]), 16'(cnt_m[1]), 16'(cnt_m[0])};
    chk("level", 64'(level_o), 64'(sz));
    chk("s_ready", 64'(s_ready_o), 64'(sz < DEPTH));
    chk("m_valid", 64'(m_valid_o), 64'(sz > 0));
    chk("m_data", 64'(m_data_o), (sz > 0) ? 64'(exp_q[0]) : 64'd0);
    chk("m_last", 64'(m_last_o), 64'((sz > 0) && (pops_m % BATCH == BATCH - 1)));
    chk("err_counts", err_counts_o, ec);
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge. Drives one cycle, advances the model at the
  // rising edge, and checks at the next falling edge.
  task automatic cycle(input logic v, input logic [31:0] d, input logic r, input logic c);
    bit push, pop;
    logic [31:0] tmp;
    s_valid_i = v;
    s_data_i  = d;
    m_ready_i = r;
    clear_i   = c;
    push = v && (exp_q.size() < DEPTH);
    pop  = r && (exp_q.size() > 0);
    @(posedge clk);
    if (pop) begin
      tmp = exp_q.pop_front();
      pops_m++;
    end
    if (push) begin
      exp_q.push_back(d & ~32'h0C00_0000);
      for (int i = 0; i < 4; i++)
        if (d[28+i] && cnt_m[i] < CNT_MAX) cnt_m[i]++;
    end
    if (c) for (int i = 0; i < 4; i++) cnt_m[i] = 0;
    @(negedge clk);
    check_model();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    check_model();
    reset = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        r;
    logic        c;
    logic [31:0] e_data;
    logic        e_valid;
    logic [3:0]  e_level;
    logic        e_last;
    logic [63:0] e_cnt;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int last_mask, beat_no;
    logic v, r, c;

    vecs[0] = '{1'b1, 32'h8000_0005, 1'b1, 1'b0, 32'h8000_0005, 1'b1, 4'd1, 1'b0, 64'h0001_0000_0000_0000};
    vecs[1] = '{1'b1, 32'h0C00_0001, 1'b1, 1'b0, 32'h0000_0001, 1'b1, 4'd1, 1'b0, 64'h0001_0000_0000_0000};
    vecs[2] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0001, 1'b1, 4'd1, 1'b0, 64'h0001_0000_0000_0000};
    vecs[3] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 4'd0, 1'b0, 64'h0001_0000_0000_0000};
    vecs[4] = '{1'b1, 32'h2000_0000, 1'b0, 1'b0, 32'h2000_0000, 1'b1, 4'd1, 1'b0, 64'h0001_0000_0001_0000};
    vecs[5] = '{1'b1, 32'hF000_00AB, 1'b1, 1'b0, 32'hF000_00AB, 1'b1, 4'd1, 1'b1, 64'h0002_0001_0002_0001};
    vecs[6] = '{1'b1, 32'h1000_0000, 1'b0, 1'b1, 32'hF000_00AB, 1'b1, 4'd2, 1'b1, 64'h0000_0000_0000_0000};
    vecs[7] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h1000_0000, 1'b1, 4'd1, 1'b0, 64'h0000_0000_0000_0000};
    vecs[8] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 4'd0, 1'b0, 64'h0000_0000_0000_0000};

    s_valid_i = 1'b0; s_data_i = '0; m_ready_i = 1'b0; clear_i = 1'b0;
    sm_s_valid = 1'b0; sm_s_data = '0; sm_m_ready = 1'b0; sm_clear = 1'b0;
    model_reset();

    // reset state, then first push on the first edge after release
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].c);
      chk($sformatf("vec%0d_data", i), 64'(m_data_o), 64'(vecs[i].e_data));
      chk($sformatf("vec%0d_valid", i), 64'(m_valid_o), 64'(vecs[i].e_valid));
      chk($sformatf("vec%0d_level", i), 64'(level_o), 64'(vecs[i].e_level));
      chk($sformatf("vec%0d_last", i), 64'(m_last_o), 64'(vecs[i].e_last));
      chk($sformatf("vec%0d_cnt", i), err_counts_o, vecs[i].e_cnt);
    end

    // fill to DEPTH with the host stalled, hold off a 9th word, then drain
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0);
    chk("full_level", 64'(level_o), 64'd8);
    chk("full_s_ready", 64'(s_ready_o), 64'd0);
    cycle(1'b1, 32'h0000_0099, 1'b0, 1'b0);
    chk("held_off_level", 64'(level_o), 64'd8);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("drain%0d", i), 64'(m_data_o), 64'(i));
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
    end
    chk("drained_level", 64'(level_o), 64'd0);

    // m_last_o on beats 4 and 8 of a 10-word stream
    apply_reset();
    last_mask = 0;
    beat_no = 0;
    for (int i = 0; i < 12; i++) begin
      if (m_valid_o) begin
        beat_no++;
        if (m_last_o) last_mask |= (1 << beat_no);
      end
      cycle(i < 10, 32'h100 + 32'(i), 1'b1, 1'b0);
    end
    chk("last_beats", 64'(last_mask), 64'((1 << 4) | (1 << 8)));
    chk("stream_beats", 64'(beat_no), 64'd10);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      r = (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 40) == 0);
      cycle(v, $urandom, r, c);
    end

    // asynchronous reset with five words buffered
    apply_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'hF000_0010 + 32'(i), 1'b0, 1'b0);
    chk("pre_reset_level", 64'(level_o), 64'd5);
    #2 reset = 1'b1;
    #1;
    chk("async_level", 64'(level_o), 64'd0);
    chk("async_m_valid", 64'(m_valid_o), 64'd0);
    chk("async_s_ready", 64'(s_ready_o), 64'd1);
    chk("async_m_data", 64'(m_data_o), 64'd0);
    chk("async_m_last", 64'(m_last_o), 64'd0);
    chk("async_err", err_counts_o, 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b1, 32'h4000_0042, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    s_valid_i = 1'b0; m_ready_i = 1'b0; clear_i = 1'b0;

    // small instance: 2-bit saturation, clear beats increment, BATCH=1
    for (int i = 0; i < 4; i++) begin
      sm_s_valid = 1'b1; sm_s_data = 32'h2000_0000 | 32'(i); sm_m_ready = 1'b1; sm_clear = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("sm_valid%0d", i), 64'(sm_m_valid), 64'd1);
      chk($sformatf("sm_last%0d", i), 64'(sm_m_last), 64'd1);
      chk($sformatf("sm_data%0d", i), 64'(sm_m_data), 64'(32'h2000_0000 | 32'(i)));
    end
    chk("sm_saturated", 64'(sm_err), 64'h0C);
    sm_clear = 1'b1; sm_s_data = 32'h2000_0004;
    @(posedge clk);
    @(negedge clk);
    chk("sm_clear_wins", 64'(sm_err), 64'h00);
    sm_clear = 1'b0; sm_s_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("sm_empty_valid", 64'(sm_m_valid), 64'd0);
    chk("sm_empty_last", 64'(sm_m_last), 64'd0);
    chk("sm_empty_level", 64'(sm_level), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hash_resp_buffer.md
HASH_RESP_BUFFER -- requirements
Module: hash_resp_buffer

Interface
REQ-001 SHALL have parameter KEY_WIDTH, default 4, key width of the hash table feeding this block; informational only.
REQ-002 SHALL have parameter DATA_WIDTH, default 26, read-data field width; KEY_WIDTH+DATA_WIDTH+2 SHALL equal 32.
REQ-003 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, at least 2.
REQ-004 SHALL have parameter BATCH, default 4, output beats per m_last_o group; at least 1.
REQ-005 SHALL have parameter CNT_WIDTH, default 16, width of each error counter.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 s_data_i  input  32  hash-table response word: [31] key_already_present, [30] no_element_found, [29] no_write_space, [28] no_deletion_target, [27:26] reserved, [DATA_WIDTH-1:0] read data.
REQ-009 s_valid_i  input  1  response word valid.
REQ-010 s_ready_o  output  1  buffer can accept a word.
REQ-011 m_data_o  output  32  buffered response word to host.
REQ-012 m_valid_o  output  1  m_data_o valid.
REQ-013 m_ready_i  input  1  host accepts word.
REQ-014 m_last_o  output  1  marks final beat of a BATCH group.
REQ-015 clear_i  input  1  synchronous zeroing of error counters.
REQ-016 err_counts_o  output  4*CNT_WIDTH  counters, [CNT_WIDTH-1:0]=no_deletion_target, next=no_write_space, next=no_element_found, top=key_already_present.
REQ-017 level_o  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-018 Push SHALL occur when s_valid_i && s_ready_o; pop when m_valid_o && m_ready_i.
REQ-019 s_ready_o SHALL equal (level < DEPTH), independent of m_ready_i; no push when full, even with simultaneous pop.
REQ-020 m_valid_o SHALL equal (level > 0); m_data_o SHALL present the oldest entry, stable while m_valid_o && !m_ready_i.
REQ-021 Latency: a word pushed into an empty FIFO at edge N SHALL appear on m_data_o with m_valid_o high after edge N.
REQ-022 Stored word SHALL have bits [27:26] forced to 0; all other bits stored unchanged.
REQ-023 Simultaneous push and pop SHALL leave level unchanged and preserve FIFO order.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH without loss or duplication.
REQ-025 On each push, every counter whose flag bit is 1 in s_data_i SHALL increment by 1, saturating at 2^CNT_WIDTH-1.
REQ-026 clear_i high SHALL zero all counters at the next edge; clear SHALL win over a same-cycle increment.
REQ-027 Beat counter SHALL count pops 0..BATCH-1 and wrap to 0; m_last_o = m_valid_o && (beat count == BATCH-1).
REQ-028 BATCH=1 SHALL assert m_last_o on every valid beat.
REQ-029 No input SHALL be combinationally routed to m_valid_o or s_ready_o.

Reset
REQ-030 reset high SHALL immediately force level_o=0, s_ready_o=1, m_valid_o=0, m_last_o=0, m_data_o=0, err_counts_o=0, beat count=0, pointers=0.
REQ-031 Reset asserted mid-transfer SHALL discard all buffered words; no partial word SHALL be emitted after release.
REQ-032 First push SHALL be accepted on the first edge after reset deasserts.

Verification
REQ-033 Reset, push 0x8000_0005, m_ready_i=1 -> one cycle later m_data_o=0x8000_0005, m_valid_o=1; key_already_present counter=1.
REQ-034 m_ready_i=0, push DEPTH words 0..7 -> level_o=8, s_ready_o=0; 9th word held off; release m_ready_i -> words 0..7 out in order.
REQ-035 Push 0x0C00_0001 -> output 0x0000_0001; no counter change.
REQ-036 CNT_WIDTH=2, push four words with bit 29 set -> no_write_space counter=3 (saturated); clear_i with a fifth such push -> 0.
REQ-037 BATCH=4, stream 10 words with m_ready_i=1 -> m_last_o on beats 4 and 8 only.
REQ-038 Reset asserted with level_o=5 -> m_valid_o=0 and level_o=0 immediately, without a clock edge.
